key_expand_seq: RTL

Iterative, multi-mode AES key-schedule engine supporting AES-128, AES-192 and AES-256, with the mode chosen per request at runtime.
- Generates one 32-bit schedule word per clock into an internal word store.
- Exposes any round key through an indexed read port.
- Sits between the key-load interface and the round datapath.
- Replaces the fixed-width, fully unrolled combinational expanders with a single small sequential block.

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/key_expand_seq_if.sv | 33 +++
 rtl/key_expand_seq_subbytes.sv | 19 +
 rtl/key_expand_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions for the key-schedule engine.
//                Key-length encodings, Nk/Nr/Wt lookups, GF(2^8) helpers
//                and the AES S-box. The S-box is computed arithmetically
//                from its definition: the multiplicative inverse in GF(2^8),
//                followed by the affine transform.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_RSV = 2'd3
    } key_len_e;

    // Key length in 32-bit words; 0 flags the reserved encoding.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'd0:    nk_of = 4'd4;
            2'd1:    nk_of = 4'd6;
            2'd2:    nk_of = 4'd8;
            default: nk_of = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd0:    nr_of = 4'd10;
            2'd1:    nr_of = 4'd12;
            2'd2:    nr_of = 4'd14;
            default: nr_of = 4'd0;
        endcase
    endfunction

    // Total schedule length in words, 4*(Nr+1).
    function automatic logic [5:0] wt_of(input logic [1:0] kl);
        case (kl)
            2'd0:    wt_of = 6'd44;
            2'd1:    wt_of = 6'd52;
            2'd2:    wt_of = 6'd60;
            default: wt_of = 6'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        gf_mul = p;
    endfunction

    // inv = a^254 = a^(2+4+...+128); zero maps to zero naturally.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_expand_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_expand_seq_if
//  Description : Request / round-key bus of the key-schedule engine.
//                master : key loader and round datapath side
//                slave  : key_expand_seq
//                start/key_len/key request an expansion; busy/done/err/nr
//                report status; rk_idx/rk_out/rk_valid read round keys.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_expand_seq_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;

    modport master (
        output start, key_len, key, rk_idx,
        input  busy, done, err, nr, rk_out, rk_valid
    );

    modport slave (
        input  start, key_len, key, rk_idx,
        output busy, done, err, nr, rk_out, rk_valid
    );
endinterface
`default_nettype wire

// File: rtl/key_expand_seq_subbytes.sv
`default_nettype none
// ============================================================================
//  Module      : key_expand_seq_subbytes
//  Description : 32-bit SubBytes (SubWord): S-box applied to each byte.
//                i_word : input word
//                o_word : substituted word
//  Revision    : 1.0  initial release
// ============================================================================
module key_expand_seq_subbytes
    import aes_pkg::*;
(
    input  wire logic [31:0] i_word,
    output logic      [31:0] o_word
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
    end
endmodule
`default_nettype wire

// File: rtl/key_expand_seq.sv
`default_nettype none
// ============================================================================
//  Module      : key_expand_seq
//  Description : Iterative AES-128/192/256 key schedule. Loads Nk key words
//                on the accepting edge, then produces one schedule word per
//                clock into a word store; any round key is readable through
//                an indexed port once the schedule is complete.
//                clk, rst : clock, asynchronous active-high reset
//                bus      : key_expand_seq_if.slave request/round-key bus
//  Revision    : 1.0  initial release
// ============================================================================
module key_expand_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,   // 4, 6 or 8
    parameter int REG_RD = 1    // 1: registered round-key read, 0: combinational
)
(
    input  wire logic        clk,
    input  wire logic        rst,
    key_expand_seq_if.slave  bus
);
    localparam int c_WORDS = 4 * (MAX_NK + 7);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_w [c_WORDS];
    logic [5:0]  r_i;       // next word to produce
    logic [2:0]  r_j;       // r_i mod Nk
    logic [3:0]  r_nk;
    logic [3:0]  r_nr;
    logic [7:0]  r_rcon;
    logic        r_err;

    logic        w_accept;
    logic        w_reject;
    logic [3:0]  w_req_nk;
    logic        w_illegal;
    logic [5:0]  w_last_idx;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [31:0] w_new;

    assign w_req_nk   = nk_of(bus.key_len);
    assign w_illegal  = (bus.key_len == KL_RSV) || (int'(w_req_nk) > MAX_NK);
    assign w_last_idx = {r_nr, 2'b00} + 6'd3;     // Wt-1 = 4*Nr+3

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (w_illegal) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                if (r_i == w_last_idx) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Word generation ----------------
    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - {2'b00, r_nk}];
    // One SubWord instance serves both the RotWord step and the
    // AES-256 mid-key step; they never occur on the same word.
    assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    key_expand_seq_subbytes u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_j == 3'd0)
            w_temp = w_sub ^ {r_rcon, 24'h000000};
        else if (r_nk == 4'd8 && r_j == 3'd4)
            w_temp = w_sub;
    end

    assign w_new = w_back ^ w_temp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= 6'd0;
            r_j     <= 3'd0;
            r_nk    <= 4'd0;
            r_nr    <= 4'd0;
            r_rcon  <= 8'h00;
            r_err   <= 1'b0;
            for (int k = 0; k < c_WORDS; k++) r_w[k] <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_reject;
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(w_req_nk)) r_w[k] <= bus.key[255 - 32*k -: 32];
                end
                r_nk   <= w_req_nk;
                r_nr   <= nr_of(bus.key_len);
                r_i    <= {2'b00, w_req_nk};
                r_j    <= 3'd0;
                r_rcon <= 8'h01;
            end else if (r_state == S_EXPAND) begin
                r_w[r_i] <= w_new;
                r_i      <= r_i + 6'd1;
                // Nk=8 wraps naturally: r_nk[2:0]-1 = 7.
                r_j      <= (r_j == r_nk[2:0] - 3'd1) ? 3'd0 : r_j + 3'd1;
                if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
            end
        end
    end

    // ---------------- Status ----------------
    assign bus.busy = (r_state == S_EXPAND);
    assign bus.done = (r_state == S_DONE);
    assign bus.err  = r_err;
    assign bus.nr   = r_nr;

    // ---------------- Round-key read ----------------
    logic         w_rk_valid;
    logic [5:0]   w_base;
    logic [127:0] w_rk;

    assign w_rk_valid = (r_state == S_DONE) && (bus.rk_idx <= r_nr);
    assign w_base     = {bus.rk_idx, 2'b00};
    assign w_rk       = w_rk_valid ? {r_w[w_base], r_w[w_base + 6'd1],
                                      r_w[w_base + 6'd2], r_w[w_base + 6'd3]}
                                   : 128'h0;

    if (REG_RD != 0) begin : g_rd_reg
        logic [127:0] r_rk_out;
        logic         r_rk_valid;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rk_out   <= 128'h0;
                r_rk_valid <= 1'b0;
            end else begin
                r_rk_out   <= w_rk;
                r_rk_valid <= w_rk_valid;
            end
        end
        assign bus.rk_out   = r_rk_out;
        assign bus.rk_valid = r_rk_valid;
    end else begin : g_rd_comb
        assign bus.rk_out   = w_rk;
        assign bus.rk_valid = w_rk_valid;
    end

endmodule
`default_nettype wire
